// File: rtl/mat_pkg.sv
// Shared types and helpers for the matrix-multiply stream controller.
package mat_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } mat_state_e;

  // Address/counter width for a range of x values: max(1, clog2(x)).
  function automatic int clog2w(input int x);
    return (x <= 2) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/mat_control_wrap_cntr.sv
// Modulo-MOD counter with enable and synchronous clear; wraps MOD-1 -> 0.
module mat_control_wrap_cntr #(
  parameter int MOD = 4,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] TOP = W'(MOD - 1);

  // Count on enable; reset and clear both return to zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TOP) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/mat_control.sv
// Sequencer for a systolic matrix multiply: streams A/B slices tile by tile,
// flushes the array after each tile and signals job completion.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; counters cleared on start
// S_STREAM | issuing one A/B read per unstalled cycle, k = 0..K-1
// S_DRAIN  | DRAIN unstalled flush cycles; tile_valid on the last one
// S_DONE   | one-cycle done pulse, then back to idle
module mat_control
  import mat_pkg::*;
#(
  parameter int N1    = 4,
  parameter int N2    = 4,
  parameter int MA    = 8,
  parameter int MB    = 8,
  parameter int K     = 8,
  parameter int DRAIN = N1 + N2 - 1,
  localparam int AW_K  = clog2w(K),
  localparam int AW_SA = clog2w(MA / N1),
  localparam int AW_SB = clog2w(MB / N2),
  localparam int AW_RA = clog2w(MA * K / N1),
  localparam int AW_RB = clog2w(MB * K / N2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [AW_RA-1:0] rd_addr_A,
  output logic [AW_RB-1:0] rd_addr_B,
  output logic [AW_K-1:0]  k_cntr,
  output logic [AW_SA-1:0] slice_cntr_A,
  output logic [AW_SB-1:0] slice_cntr_B,
  output logic             clear_acc,
  output logic             tile_valid
);

  localparam int AW_D = clog2w(DRAIN);

  if ((MA % N1) != 0) begin : g_bad_ma
    $error("mat_control: MA must be a multiple of N1");
  end
  if ((MB % N2) != 0) begin : g_bad_mb
    $error("mat_control: MB must be a multiple of N2");
  end
  if (K < 1) begin : g_bad_k
    $error("mat_control: K must be at least 1");
  end
  if (DRAIN < 1) begin : g_bad_drain
    $error("mat_control: DRAIN must be at least 1");
  end

  mat_state_e       state;
  logic [AW_D-1:0]  d_cntr;
  logic             job_start;
  logic             stream_go;
  logic             drain_go;
  logic             k_last;
  logic             d_last;
  logic             sa_last;
  logic             sb_last;
  logic             tile_end;
  logic             sa_en;
  logic [31:0]      prod_a;
  logic [31:0]      prod_b;

  assign job_start = (state == S_IDLE) && start;
  assign stream_go = (state == S_STREAM) && !stall;
  assign drain_go  = (state == S_DRAIN) && !stall;

  assign k_last  = (k_cntr == AW_K'(K - 1));
  assign d_last  = (d_cntr == AW_D'(DRAIN - 1));
  assign sa_last = (slice_cntr_A == AW_SA'(MA / N1 - 1));
  assign sb_last = (slice_cntr_B == AW_SB'(MB / N2 - 1));

  assign tile_end = drain_go && d_last;
  assign sa_en    = tile_end && sb_last;

  mat_control_wrap_cntr #(.MOD(K), .W(AW_K)) u_k_cntr (
    .clk (clk),
    .rst (rst),
    .clr (job_start),
    .en  (stream_go),
    .cnt (k_cntr)
  );

  mat_control_wrap_cntr #(.MOD(DRAIN), .W(AW_D)) u_d_cntr (
    .clk (clk),
    .rst (rst),
    .clr (job_start),
    .en  (drain_go),
    .cnt (d_cntr)
  );

  mat_control_wrap_cntr #(.MOD(MB / N2), .W(AW_SB)) u_sb_cntr (
    .clk (clk),
    .rst (rst),
    .clr (job_start),
    .en  (tile_end),
    .cnt (slice_cntr_B)
  );

  mat_control_wrap_cntr #(.MOD(MA / N1), .W(AW_SA)) u_sa_cntr (
    .clk (clk),
    .rst (rst),
    .clr (job_start),
    .en  (sa_en),
    .cnt (slice_cntr_A)
  );

  // Products are formed at 32 bits so nothing is lost before the final resize.
  assign prod_a    = 32'(slice_cntr_A) * 32'(K) + 32'(k_cntr);
  assign prod_b    = 32'(slice_cntr_B) * 32'(K) + 32'(k_cntr);
  assign rd_addr_A = AW_RA'(prod_a);
  assign rd_addr_B = AW_RB'(prod_b);

  // Strobes come straight from registered state/counters; stall masks them in
  // the same cycle so a frozen cycle never issues a read or a tile result.
  assign rd_en      = stream_go;
  assign clear_acc  = stream_go && (k_cntr == '0);
  assign tile_valid = tile_end;

  // State sequencing with registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_STREAM;
            busy  <= 1'b1;
          end
        end
        S_STREAM: begin
          if (!stall && k_last) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (tile_end) begin
            if (sa_last && sb_last) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_STREAM;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_control.sv
// Directed bench for mat_control: default 2x2-tile job and a K=1 single tile.
module tb_mat_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       busy, done, rd_en, clear_acc, tile_valid;
  logic [3:0] rd_addr_A, rd_addr_B;
  logic [2:0] k_cntr;
  logic [0:0] slice_cntr_A, slice_cntr_B;

  logic       start1 = 1'b0;
  logic       stall1 = 1'b0;
  logic       busy1, done1, rd_en1, clear_acc1, tile_valid1;
  logic [0:0] rd_addr_A1, rd_addr_B1, k_cntr1, slice_cntr_A1, slice_cntr_B1;

  int errors = 0;
  int checks = 0;

  mat_control dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stall        (stall),
    .busy         (busy),
    .done         (done),
    .rd_en        (rd_en),
    .rd_addr_A    (rd_addr_A),
    .rd_addr_B    (rd_addr_B),
    .k_cntr       (k_cntr),
    .slice_cntr_A (slice_cntr_A),
    .slice_cntr_B (slice_cntr_B),
    .clear_acc    (clear_acc),
    .tile_valid   (tile_valid)
  );

  mat_control #(.N1(4), .N2(2), .MA(4), .MB(2), .K(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .start        (start1),
    .stall        (stall1),
    .busy         (busy1),
    .done         (done1),
    .rd_en        (rd_en1),
    .rd_addr_A    (rd_addr_A1),
    .rd_addr_B    (rd_addr_B1),
    .k_cntr       (k_cntr1),
    .slice_cntr_A (slice_cntr_A1),
    .slice_cntr_B (slice_cntr_B1),
    .clear_acc    (clear_acc1),
    .tile_valid   (tile_valid1)
  );

  // Packed view of the default DUT:
  // {busy, done, rd_en, clear_acc, tile_valid, addr_A[3:0], addr_B[3:0], k[2:0], sa, sb}
  function automatic logic [17:0] obs0();
    return {busy, done, rd_en, clear_acc, tile_valid, rd_addr_A, rd_addr_B,
            k_cntr, slice_cntr_A, slice_cntr_B};
  endfunction

  // Expected view at effective job cycle e (1 = first STREAM cycle).
  // Each tile is 8 read cycles then 7 drain cycles; done at e=61.
  function automatic void model(input int e, input bit stalled,
                                output logic [17:0] v, output logic [17:0] m);
    int t, p, sa, sb;
    v = '0;
    m = 18'h3E000;
    if (e >= 1 && e <= 60) begin
      t  = (e - 1) / 15;
      p  = (e - 1) % 15;
      sa = t / 2;
      sb = t % 2;
      v[17] = 1'b1;
      v[1]  = sa[0];
      v[0]  = sb[0];
      m     = m | 18'h0001F;
      if (p < 8) begin
        v[15]   = !stalled;
        v[14]   = !stalled && (p == 0);
        v[4:2]  = 3'(p);
        v[12:9] = 4'(sa * 8 + p);
        v[8:5]  = 4'(sb * 8 + p);
        m       = m | 18'h01FE0;
      end else begin
        v[13]  = (p == 14) && !stalled;
        v[4:2] = 3'd0;
      end
    end else if (e == 61) begin
      v[17] = 1'b1;
      v[16] = 1'b1;
    end
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; stall = 1'b0; start1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Runs a default-config job started at cycle 0 and compares every cycle.
  task automatic run_job(input int stall_at, input int stall_len, input bit hold,
                         input int ncyc, input string name);
    int          eff;
    bit          st;
    logic [17:0] v, m, o;
    @(posedge clk); #1;
    start = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_busy: got %b expected 0", name, busy);
    end
    eff = 1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start = hold;
      st    = (c >= stall_at) && (c < stall_at + stall_len);
      stall = st;
      @(negedge clk);
      model(eff, st, v, m);
      o = obs0();
      checks++;
      if ((o & m) !== (v & m)) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h (mask %h)", name, c, o & m, v & m, m);
      end
      if (!st) eff++;
      if (hold && eff == 63) eff = 1;
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; stall = 1'b1; start1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (obs0() !== 18'h0) begin
        errors++;
        $display("FAIL reset_dut0: got %h expected 0", obs0());
      end
      checks++;
      if ({busy1, done1, rd_en1, clear_acc1, tile_valid1, rd_addr_A1, rd_addr_B1,
           k_cntr1, slice_cntr_A1, slice_cntr_B1} !== 10'h0) begin
        errors++;
        $display("FAIL reset_dut1: busy=%b rd_en=%b expected all 0", busy1, rd_en1);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; stall = 1'b0; start1 = 1'b0;
  endtask

  task automatic test_full_job();
    run_job(0, 0, 1'b0, 64, "full_job");
  endtask

  task automatic test_stall();
    run_job(6, 3, 1'b0, 67, "stall");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 20) rst = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got %b expected 1", busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs0() !== 18'h0) begin
      errors++;
      $display("FAIL mid_reset: got %h expected 0", obs0());
    end
    run_job(0, 0, 1'b0, 63, "after_reset");
  endtask

  task automatic test_start_held();
    run_job(0, 0, 1'b1, 70, "start_held");
    do_reset();
  endtask

  // K=1, one tile, DRAIN=5: expected {busy, done, rd_en, clear_acc, tile_valid}.
  task automatic test_single_tile();
    logic [4:0] tbl [0:9];
    logic [4:0] o;
    tbl = '{5'b00000, 5'b10110, 5'b10000, 5'b10000, 5'b10000,
            5'b10000, 5'b10001, 5'b11000, 5'b00000, 5'b00000};
    @(posedge clk); #1;
    start1 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        start1 = 1'b0;
      end
      @(negedge clk);
      o = {busy1, done1, rd_en1, clear_acc1, tile_valid1};
      checks++;
      if (o !== tbl[c]) begin
        errors++;
        $display("FAIL single_tile cycle %0d: got %b expected %b", c, o, tbl[c]);
      end
      if (c == 1) begin
        checks++;
        if ({rd_addr_A1, rd_addr_B1, k_cntr1, slice_cntr_A1, slice_cntr_B1} !== 5'b0) begin
          errors++;
          $display("FAIL single_tile_addr: A=%b B=%b k=%b expected 0", rd_addr_A1, rd_addr_B1, k_cntr1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_stall();
    test_reset_mid();
    test_start_held();
    test_single_tile();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mat_control.md
MAT_CONTROL -- requirements
Module: mat_control

Interface
REQ-001 Parameter N1, default 4: systolic array rows (A slice height).
REQ-002 Parameter N2, default 4: systolic array columns (B slice width).
REQ-003 Parameter MA, default 8: rows of matrix A; multiple of N1.
REQ-004 Parameter MB, default 8: columns of matrix B; multiple of N2.
REQ-005 Parameter K, default 8: shared inner dimension.
REQ-006 Parameter DRAIN, default N1+N2-1: systolic flush cycles per tile.
REQ-007 Widths: AW_K=max(1,clog2(K)), AW_SA=max(1,clog2(MA/N1)), AW_SB=max(1,clog2(MB/N2)), AW_RA=max(1,clog2(MA*K/N1)), AW_RB=max(1,clog2(MB*K/N2)).
REQ-008 clk  input  1  single clock; all logic rising-edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 start  input  1  job request; sampled only in IDLE.
REQ-011 stall  input  1  freeze request from downstream.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse at job end.
REQ-014 rd_en  output  1  rd_addr_A/rd_addr_B valid this cycle.
REQ-015 rd_addr_A  output  AW_RA  A buffer address.
REQ-016 rd_addr_B  output  AW_RB  B buffer address.
REQ-017 k_cntr  output  AW_K  inner-dimension index.
REQ-018 slice_cntr_A  output  AW_SA  current A slice.
REQ-019 slice_cntr_B  output  AW_SB  current B slice.
REQ-020 clear_acc  output  1  pulse: PEs reset accumulators (first k of tile).
REQ-021 tile_valid  output  1  pulse: tile (slice_cntr_A, slice_cntr_B) result ready.

Function
REQ-022 FSM states IDLE, STREAM, DRAIN, DONE, all registered outputs.
REQ-023 IDLE: start=1 -> STREAM next cycle; k_cntr, slice counters cleared.
REQ-024 STREAM, stall=0: rd_en=1; rd_addr_A=slice_cntr_A*K+k_cntr; rd_addr_B=slice_cntr_B*K+k_cntr; k_cntr increments.
REQ-025 clear_acc=1 exactly when rd_en=1 and k_cntr=0.
REQ-026 STREAM, k_cntr=K-1 and not stalled -> DRAIN, k_cntr wraps to 0.
REQ-027 DRAIN lasts DRAIN unstalled cycles, rd_en=0; tile_valid=1 on the last, with slice counters still showing the finished tile.
REQ-028 Tile order: slice_cntr_B inner, slice_cntr_A outer; after DRAIN, advance and return to STREAM, or go to DONE if slice_cntr_A=MA/N1-1 and slice_cntr_B=MB/N2-1.
REQ-029 DONE: done=1 for one cycle, then IDLE; stall ignored in DONE.
REQ-030 stall=1 in STREAM or DRAIN: state, all counters, and addresses hold; rd_en, clear_acc, tile_valid forced 0.
REQ-031 start outside IDLE ignored; no queuing.
REQ-032 Single-tile config (MA=N1, MB=N2): one STREAM/DRAIN pass then DONE.
REQ-033 K=1: STREAM lasts one cycle; clear_acc and rd_en coincide.
REQ-034 Address products computed at full width; no truncation for legal parameters.

Reset
REQ-035 rst=1 forces IDLE next edge from any state, including mid-tile.
REQ-036 Reset values: busy, done, rd_en, clear_acc, tile_valid=0; rd_addr_A, rd_addr_B, k_cntr, slice_cntr_A, slice_cntr_B=0.
REQ-037 rst has priority over start and stall.

Structure
REQ-038 State encoding typedef and width helper (max(1,clog2(x))) in shared package mat_pkg.
REQ-039 One sub-module: wrap counter (mod-N, enable, sync clear), instantiated for k_cntr, slice_cntr_B, slice_cntr_A, and the drain count.
REQ-040 Elaboration check: MA%N1==0, MB%N2==0, K>=1, DRAIN>=1.

Verification
REQ-041 N1=N2=4, MA=MB=K=8, DRAIN=7, start at cycle 0 -> 4 tiles, each 8 rd_en + 7 drain; tile order (A,B)=(0,0),(0,1),(1,0),(1,1); done at cycle 61.
REQ-042 Same config, tile (1,1) -> rd_addr_A 8..15, rd_addr_B 8..15; clear_acc with address 8/8 only.
REQ-043 stall=1 for 3 cycles at k_cntr=5 -> rd_en low for 3 cycles, addresses hold, resume at k_cntr=5; done delayed 3 cycles.
REQ-044 rst at cycle 20 mid-job -> all outputs 0 next cycle; new start runs a full job from tile (0,0).
REQ-045 start held high through the job -> exactly one job; restart only after the IDLE cycle following done.
REQ-046 MA=N1=4, MB=N2=2, K=1 -> one rd_en cycle with clear_acc, DRAIN cycles, tile_valid, done.
